// File: rtl/plot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : plot_pkg
// Purpose  : Shared geometry, colour and state constants for the plot sink.
// Revision : 1.0
// ============================================================================
package plot_pkg;

    localparam int WIDTH   = 160;
    localparam int HEIGHT  = 120;
    localparam int ADDR_W  = 15;
    localparam int FB_SIZE = WIDTH * HEIGHT;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // y*160 + x built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px,
                                                     input logic [6:0] py);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = {{(ADDR_W-7){1'b0}}, py};
        xw = {{(ADDR_W-8){1'b0}}, px};
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : plot_fifo
// Purpose  : Small synchronous FIFO; pointers carry an extra wrap bit.
// Revision : 1.0
// ============================================================================
module plot_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
    end

    assign dout  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/plot_sink.sv
`default_nettype none
// ============================================================================
// Module   : plot_sink
// Purpose  : Range-checks and buffers pixel plots, writes them to the
//            framebuffer through an acked port, and performs full clears.
// Revision : 1.0
// ============================================================================
module plot_sink
    import plot_pkg::*;
#(
    parameter int WIDTH    = plot_pkg::WIDTH,
    parameter int HEIGHT   = plot_pkg::HEIGHT,
    parameter int COLOUR_W = 3,
    parameter int DEPTH    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                plot,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    output logic                ready,
    input  logic                clear_req,
    output logic                clear_done,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    input  logic                fb_ack,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          range_err
);

    localparam int                DATA_W    = ADDR_W + COLOUR_W;
    localparam logic [8:0]        X_LIM     = WIDTH[8:0];
    localparam logic [7:0]        Y_LIM     = HEIGHT[7:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [1:0]          r_state;
    logic                r_fb_we;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [COLOUR_W-1:0] r_fb_data;
    logic                r_clear_pending;
    logic                r_clear_done;
    logic                r_overflow;
    logic [7:0]          r_range_err;
    logic                r_alive;

    logic                w_in_range;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_clear_last;
    logic [DATA_W-1:0]   w_fifo_din;
    logic [DATA_W-1:0]   w_fifo_dout;
    logic [ADDR_W-1:0]   w_pop_addr;
    logic [COLOUR_W-1:0] w_pop_colour;

    assign w_in_range = ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
    assign w_push     = plot & ready & w_in_range;
    assign w_fifo_din = {pixel_addr(x, y), colour};
    assign {w_pop_addr, w_pop_colour} = w_fifo_dout;

    plot_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Pending clears pre-empt the FIFO, both from IDLE and at the end of a write.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_IDLE:  w_pop = ~r_clear_pending & ~w_empty;
            ST_WRITE: w_pop = fb_ack & ~r_clear_pending & ~w_empty;
            default:  w_pop = 1'b0;
        endcase
    end

    assign w_clear_last = (r_state == ST_CLEAR) && fb_ack && (r_fb_addr == LAST_ADDR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_clear_pending) begin
                        r_state   <= ST_CLEAR;
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= '0;
                        r_fb_data <= '0;
                    end else if (!w_empty) begin
                        r_state   <= ST_WRITE;
                        r_fb_we   <= 1'b1;
                        r_fb_addr <= w_pop_addr;
                        r_fb_data <= w_pop_colour;
                    end
                end
                ST_WRITE: begin
                    if (fb_ack) begin
                        if (r_clear_pending) begin
                            r_state   <= ST_CLEAR;
                            r_fb_addr <= '0;
                            r_fb_data <= '0;
                        end else if (!w_empty) begin
                            r_fb_addr <= w_pop_addr;
                            r_fb_data <= w_pop_colour;
                        end else begin
                            r_state <= ST_IDLE;
                            r_fb_we <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_clear_last) begin
                        r_state      <= ST_IDLE;
                        r_fb_we      <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else if (fb_ack) begin
                        r_fb_addr <= r_fb_addr + ADDR_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_fb_we <= 1'b0;
                end
            endcase
        end
    end

    // A request arriving while one is pending or running is absorbed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clear_pending <= 1'b0;
        end else if (w_clear_last) begin
            r_clear_pending <= 1'b0;
        end else if (clear_req) begin
            r_clear_pending <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alive     <= 1'b0;
            r_overflow  <= 1'b0;
            r_range_err <= '0;
        end else begin
            r_alive <= 1'b1;
            if (plot && w_in_range && !ready) r_overflow <= 1'b1;
            if (plot && !w_in_range && (r_range_err != 8'hFF))
                r_range_err <= r_range_err + 8'd1;
        end
    end

    assign ready      = r_alive & ~w_full;
    assign busy       = ~w_empty | r_fb_we | r_clear_pending;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign clear_done = r_clear_done;
    assign overflow   = r_overflow;
    assign range_err  = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_plot_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_plot_sink
// Purpose  : Self-checking bench for plot_sink against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_plot_sink;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic       clear_req = 1'b0;
    logic       fb_ack = 1'b0;
    logic [7:0] x = 8'd0;
    logic [6:0] y = 7'd0;
    logic [2:0] colour = 3'd0;

    logic        ready, clear_done, fb_we, busy, overflow;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic [7:0]  range_err;

    int errors = 0;
    int checks = 0;

    logic [17:0] wr_log[$];
    logic [17:0] exp_q[$];
    int          done_cnt = 0;
    int          done_at = 0;
    int          stab_viol = 0;
    int          we_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [14:0] prev_addr = '0;
    logic [2:0]  prev_data = '0;

    plot_sink dut (
        .clock      (clock),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .ready      (ready),
        .clear_req  (clear_req),
        .clear_done (clear_done),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .fb_ack     (fb_ack),
        .busy       (busy),
        .overflow   (overflow),
        .range_err  (range_err)
    );

    always #5 clock = ~clock;

    // Inputs change 1ns after posedge, so negedge values are what the next edge sees.
    always @(negedge clock) begin
        if (fb_we === 1'b1) we_cycles <= we_cycles + 1;
        if (fb_we === 1'b1 && fb_ack === 1'b1) wr_log.push_back({fb_addr, fb_data});
        if (clear_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_at  <= wr_log.size();
        end
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (fb_we !== 1'b1 || fb_addr !== prev_addr || fb_data !== prev_data))
                stab_viol <= stab_viol + 1;
            prev_stall <= (fb_we === 1'b1) && (fb_ack === 1'b0);
            prev_addr  <= fb_addr;
            prev_data  <= fb_data;
        end
    end

    function automatic logic [17:0] ent(int px, int py, int c);
        return {15'(py * 160 + px), 3'(c)};
    endfunction

    // -1 on a length difference, otherwise number of differing entries.
    function automatic int log_diff();
        int n;
        n = 0;
        if (wr_log.size() != exp_q.size()) return -1;
        foreach (exp_q[i]) if (wr_log[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_plot(input int px, input int py, input int c);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        plot = 1'b0;
        clear_req = 1'b0;
        fb_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++;
        if ({fb_we, fb_addr, fb_data} !== 19'd0) begin
            errors++; $display("FAIL reset_fb: got we=%b addr=%0d data=%0d want 0", fb_we, fb_addr, fb_data);
        end
        checks++;
        if ({busy, overflow, clear_done, range_err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b ovf=%b done=%b rerr=%0d want 0", busy, overflow, clear_done, range_err);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        fb_ack = 1'b1;
        set_plot(3, 2, 7);
        step();
        plot = 1'b0;
        @(negedge clock);
        checks++;
        if (fb_we !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_latency: got we=%b busy=%b want 0/1", fb_we, busy);
        end
        step();
        @(negedge clock);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 15'd323 || fb_data !== 3'd7) begin
            errors++; $display("FAIL single_write: got we=%b addr=%0d data=%0d want 1/323/7", fb_we, fb_addr, fb_data);
        end
        repeat (4) step();
        @(negedge clock);
        exp_q.push_back(ent(3, 2, 7));
        checks++;
        if (log_diff() !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_log: got writes=%0d busy=%b want 1/0", wr_log.size(), busy);
        end
    endtask

    task automatic test_overflow();
        int px, py, pc;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            px = $urandom_range(0, 159);
            py = $urandom_range(0, 119);
            pc = $urandom_range(0, 7);
            set_plot(px, py, pc);
            @(negedge clock);
            checks++;
            if (ready !== (k <= 8 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL ovf_ready[%0d]: got %b want %b", k, ready, (k <= 8));
            end
            if (k <= 8) exp_q.push_back(ent(px, py, pc));
            if (k == 9) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
            step();
        end
        plot = 1'b0;
        @(negedge clock);
        checks++;
        if (overflow !== 1'b1 || fb_we !== 1'b1 || {fb_addr, fb_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b we=%b entry=%0h want 1/1/%0h", overflow, fb_we, {fb_addr, fb_data}, exp_q[0]);
        end
        step();
        fb_ack = 1'b1;
        @(negedge clock);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ovf_still_full: got %b want 0", ready); end
        step();
        @(negedge clock);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ovf_reready: got %b want 1", ready); end
        repeat (20) step();
        @(negedge clock);
        checks++;
        if (log_diff() !== 0) begin
            errors++; $display("FAIL ovf_order: got %0d writes (diff %0d) want 9", wr_log.size(), log_diff());
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b busy=%b want 1/0", overflow, busy);
        end
    endtask

    task automatic test_range();
        int we0, px, py;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            set_plot(k, k, k % 8);
            exp_q.push_back(ent(k, k, k % 8));
            step();
        end
        set_plot(200, 5, 1);
        step();
        plot = 1'b0;
        @(negedge clock);
        checks++;
        if (range_err !== 8'd1 || overflow !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL range_full: got rerr=%0d ovf=%b ready=%b want 1/0/0", range_err, overflow, ready);
        end
        fb_ack = 1'b1;
        repeat (15) step();
        we0 = we_cycles;
        set_plot(160, 0, 3);
        step();
        set_plot(0, 120, 4);
        step();
        plot = 1'b0;
        repeat (3) step();
        @(negedge clock);
        checks++;
        if (range_err !== 8'd3 || we_cycles != we0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL range_edge: got rerr=%0d we_cycles=%0d ovf=%b want 3/0/0", range_err, we_cycles - we0, overflow);
        end
        for (int k = 0; k < 260; k++) begin
            if (k % 2 == 0) begin px = $urandom_range(160, 255); py = $urandom_range(0, 127); end
            else begin px = $urandom_range(0, 255); py = $urandom_range(120, 127); end
            set_plot(px, py, 0);
            step();
        end
        set_plot(159, 119, 6);
        exp_q.push_back(ent(159, 119, 6));
        step();
        set_plot(0, 0, 5);
        exp_q.push_back(ent(0, 0, 5));
        step();
        plot = 1'b0;
        repeat (5) step();
        @(negedge clock);
        checks++;
        if (range_err !== 8'd255) begin errors++; $display("FAIL range_sat: got %0d want 255", range_err); end
        checks++;
        if (log_diff() !== 0) begin
            errors++; $display("FAIL range_log: got %0d writes (diff %0d) want %0d", wr_log.size(), log_diff(), exp_q.size());
        end
    endtask

    task automatic test_clear();
        int cyc, d0, bad;
        do_reset();
        d0 = done_cnt;
        fb_ack = 1'b1;
        clear_req = 1'b1;
        set_plot(10, 20, 3);
        step();
        clear_req = 1'b0;
        set_plot(159, 0, 5);
        step();
        plot = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 20100) begin
            if (cyc == 1000) begin
                clear_req = 1'b1;
                set_plot(7, 9, 2);
            end else begin
                clear_req = 1'b0;
                plot = 1'b0;
            end
            if (cyc == 2000) begin
                @(negedge clock);
                checks++;
                if (busy !== 1'b1 || fb_we !== 1'b1 || fb_data !== 3'd0) begin
                    errors++; $display("FAIL clear_active: got busy=%b we=%b data=%0d want 1/1/0", busy, fb_we, fb_data);
                end
            end
            step();
            cyc++;
        end
        checks++;
        if (done_cnt == d0) begin errors++; $display("FAIL clear_timeout: got no clear_done want one pulse"); end
        repeat (10) step();
        @(negedge clock);
        checks++;
        if (done_cnt - d0 != 1 || done_at != 19200) begin
            errors++; $display("FAIL clear_done: got pulses=%0d at_write=%0d want 1/19200", done_cnt - d0, done_at);
        end
        bad = 0;
        for (int i = 0; i < 19200; i++)
            if (i >= wr_log.size() || wr_log[i] !== {15'(i), 3'd0}) bad++;
        checks++;
        if (bad != 0 || wr_log.size() != 19203) begin
            errors++; $display("FAIL clear_sweep: got %0d bad of %0d writes want 0 of 19203", bad, wr_log.size());
        end
        checks++;
        if (wr_log.size() == 19203 &&
            (wr_log[19200] !== ent(10, 20, 3) || wr_log[19201] !== ent(159, 0, 5) || wr_log[19202] !== ent(7, 9, 2))) begin
            errors++;
            $display("FAIL clear_queued: got %0h %0h %0h want %0h %0h %0h", wr_log[19200], wr_log[19201], wr_log[19202],
                     ent(10, 20, 3), ent(159, 0, 5), ent(7, 9, 2));
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back_stall();
        int px, py, pc, s0;
        do_reset();
        s0 = stab_viol;
        for (int c = 0; c < 60; c++) begin
            fb_ack = c[1];
            if (ready && $urandom_range(0, 3) != 0) begin
                px = $urandom_range(0, 159);
                py = $urandom_range(0, 119);
                pc = $urandom_range(0, 7);
                set_plot(px, py, pc);
                exp_q.push_back(ent(px, py, pc));
            end else begin
                plot = 1'b0;
            end
            step();
        end
        plot = 1'b0;
        for (int c = 0; c < 40; c++) begin
            fb_ack = c[1];
            step();
        end
        @(negedge clock);
        checks++;
        if (stab_viol != s0) begin errors++; $display("FAIL stall_stable: got %0d violations want 0", stab_viol - s0); end
        checks++;
        if (log_diff() !== 0 || exp_q.size() == 0) begin
            errors++; $display("FAIL stall_order: got %0d writes (diff %0d) want %0d", wr_log.size(), log_diff(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int px, py, pc, rerr, s0;
        logic ovf;
        do_reset();
        rerr = 0;
        ovf = 1'b0;
        s0 = stab_viol;
        for (int c = 0; c < 400; c++) begin
            fb_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) begin
                px = $urandom_range(0, 175);
                py = $urandom_range(0, 127);
                pc = $urandom_range(0, 7);
                set_plot(px, py, pc);
                if (px >= 160 || py >= 120) begin
                    if (rerr < 255) rerr++;
                end else if (ready === 1'b1) begin
                    exp_q.push_back(ent(px, py, pc));
                end else begin
                    ovf = 1'b1;
                end
            end else begin
                plot = 1'b0;
            end
            step();
        end
        plot = 1'b0;
        fb_ack = 1'b1;
        repeat (20) step();
        @(negedge clock);
        checks++;
        if (log_diff() !== 0) begin
            errors++; $display("FAIL rand_log: got %0d writes (diff %0d) want %0d", wr_log.size(), log_diff(), exp_q.size());
        end
        checks++;
        if (range_err !== 8'(rerr) || overflow !== ovf) begin
            errors++; $display("FAIL rand_flags: got rerr=%0d ovf=%b want %0d/%b", range_err, overflow, rerr, ovf);
        end
        checks++;
        if (stab_viol != s0 || busy !== 1'b0) begin
            errors++; $display("FAIL rand_stable: got viol=%0d busy=%b want 0/0", stab_viol - s0, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cyc, d0;
        do_reset();
        d0 = done_cnt;
        fb_ack = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        cyc = 0;
        @(negedge clock);
        while (!(fb_we === 1'b1 && fb_addr === 15'd500) && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc >= 1000) begin errors++; $display("FAIL rst_clear_reach: got addr=%0d want 500", fb_addr); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({fb_we, fb_addr, fb_data, busy, ready, clear_done, overflow, range_err} !== 31'd0) begin
            errors++;
            $display("FAIL rst_async: got we=%b addr=%0d data=%0d busy=%b ready=%b want all 0", fb_we, fb_addr, fb_data, busy, ready);
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        wr_log.delete();
        set_plot(10, 10, 5);
        step();
        plot = 1'b0;
        repeat (30) step();
        @(negedge clock);
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0); end
        exp_q.push_back(ent(10, 10, 5));
        checks++;
        if (log_diff() !== 0) begin
            errors++; $display("FAIL rst_resume: got %0d writes (diff %0d) want 1", wr_log.size(), log_diff());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_range();
        test_clear();
        test_back_to_back_stall();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
